serial_paralelo_rx: RTL and testbench

Serial-to-parallel receiver that consumes the 1-bit stream produced by the parallel-to-serial transmitter stage. It runs on the 32x bit clock, hunts for the COM symbol 0xBC, and declares byte lock after a run of aligned COMs. Once locked, it emits each received byte with a byte-rate valid flag, treating COM as idle. It is the first stage of the receive path and feeds the downstream byte/lane logic.

---
 rtl/pcie_phy_pkg.sv | 23 ++
 rtl/com_detector.sv | 37 +++
 rtl/serial_paralelo_rx.sv | 131 +++++++++++++
 tb/tb_serial_paralelo_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_phy_pkg
//  Description : Shared PHY constants and the byte-lock FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcie_phy_pkg;

    // Width of one symbol on the serial link
    localparam int BYTE_W = 8;

    // Idle / alignment symbol, shared with the transmitter stage
    localparam logic [BYTE_W-1:0] COM_SYM = 8'hBC;

    // Byte-lock state machine
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

endpackage : pcie_phy_pkg
`default_nettype wire

// File: rtl/com_detector.sv
`default_nettype none
// ============================================================================
//  Module      : com_detector
//  Description : Sliding 8-bit window over the serial stream plus COM compare.
//                The window includes the bit being sampled this cycle, so a
//                match is visible combinationally on the edge it completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module com_detector
    import pcie_phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM_SYM = pcie_phy_pkg::COM_SYM
) (
    input  logic              clk32_f,
    input  logic              reset,
    input  logic              bit_i,
    output logic [BYTE_W-1:0] win_o,
    output logic              is_com_o
);

    // Only the seven older bits need storage; the newest comes from bit_i.
    logic [BYTE_W-2:0] sr_q;

    assign win_o    = {sr_q, bit_i};
    assign is_com_o = (win_o == COM_SYM);

    // Shift the window every cycle, regardless of lock state
    always_ff @(posedge clk32_f) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= win_o[BYTE_W-2:0];
        end
    end

endmodule : com_detector
`default_nettype wire

// File: rtl/serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_rx
//  Description : Serial-to-parallel receiver on the 32x bit clock. Hunts for
//                COM, locks after COM_LOCK aligned COMs, then emits each
//                non-COM byte with a byte-rate valid flag (COM = idle).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_paralelo_rx
    import pcie_phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM_SYM  = pcie_phy_pkg::COM_SYM,
    parameter int                COM_LOCK = 4
) (
    input  logic              clk32_f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);

    localparam logic [3:0] LOCK_N = 4'(COM_LOCK);

    logic [BYTE_W-1:0] w_win;
    logic              w_is_com;
    logic              w_boundary;

    rx_state_e         state_q,   state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        com_cnt_q, com_cnt_d;
    logic [BYTE_W-1:0] data_q,    data_d;
    logic              valid_q,   valid_d;
    logic              active_q,  active_d;

    com_detector #(
        .COM_SYM (COM_SYM)
    ) u_com_detector (
        .clk32_f  (clk32_f),
        .reset    (reset),
        .bit_i    (data_in),
        .win_o    (w_win),
        .is_com_o (w_is_com)
    );

    assign w_boundary = (bit_cnt_q == 3'd7);

    // Next-state logic for the lock FSM, counters and output registers
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;

        case (state_q)
            HUNT: begin
                // Any bit position may match; the match defines byte phase.
                if (w_is_com) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    if (LOCK_N == 4'd1) begin
                        state_d  = LOCKED;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end

            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_com) begin
                        if (com_cnt_q < LOCK_N) begin
                            com_cnt_d = com_cnt_q + 4'd1;
                        end
                        if (com_cnt_q + 4'd1 == LOCK_N) begin
                            state_d  = LOCKED;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d   = HUNT;
                        com_cnt_d = 4'd0;
                    end
                end
            end

            LOCKED: begin
                // COM is idle: drop valid but keep the last payload byte.
                if (w_boundary) begin
                    if (w_is_com) begin
                        valid_d = 1'b0;
                    end else begin
                        data_d  = w_win;
                        valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and output registers; reset overrides everything
    always_ff @(posedge clk32_f) begin
        if (reset) begin
            state_q   <= HUNT;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule : serial_paralelo_rx
`default_nettype wire

// File: tb/tb_serial_paralelo_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_paralelo_rx
//  Description : Self-checking bench for serial_paralelo_rx. A second instance
//                built with COM_LOCK = 1 shares the stimulus and reveals the
//                exact edge of the first COM match.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_rx;

    logic       clk32_f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out,  data_out1;
    logic       valid_out, valid_out1;
    logic       active,    active1;

    serial_paralelo_rx #(.COM_SYM(8'hBC), .COM_LOCK(4)) dut (
        .clk32_f   (clk32_f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    serial_paralelo_rx #(.COM_SYM(8'hBC), .COM_LOCK(1)) dut1 (
        .clk32_f   (clk32_f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out1),
        .valid_out (valid_out1),
        .active    (active1)
    );

    always #5 clk32_f = ~clk32_f;

    typedef struct {
        logic [7:0] din;
        logic       exp_v;
        logic [7:0] exp_d;
    } vec_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   edge_n;
    int   rise_n, rise1_n;
    logic prev_act, prev_act1;
    bit   valid_seen;
    exp_t sb[$];
    exp_t last_exp;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one bit, wait one edge, then record lock rises and valid activity
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk32_f);
        #1;
        edge_n++;
        if (active  && !prev_act  && rise_n  < 0) rise_n  = edge_n;
        if (active1 && !prev_act1 && rise1_n < 0) rise1_n = edge_n;
        prev_act  = active;
        prev_act1 = active1;
        if (valid_out) valid_seen = 1'b1;
    endtask

    // Send a byte MSB first; when chk is set, verify hold then pop the scoreboard
    task automatic send_byte(input logic [7:0] b, input bit chk);
        bit   hold_ok;
        exp_t e;
        hold_ok = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (chk && i != 0) begin
                if (valid_out !== last_exp.v || data_out !== last_exp.d) hold_ok = 1'b0;
            end
        end
        if (chk) begin
            check($sformatf("hold_before_%02h", b), 32'(hold_ok), 32'd1);
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("valid_after_%02h", b), 32'(valid_out), 32'(e.v));
                check($sformatf("data_after_%02h", b), 32'(data_out), 32'(e.d));
                last_exp = e;
            end
        end
    endtask

    task automatic clear_tracking();
        edge_n     = 0;
        rise_n     = -1;
        rise1_n    = -1;
        prev_act   = 1'b0;
        prev_act1  = 1'b0;
        valid_seen = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = 1'b0;
        repeat (2) @(posedge clk32_f);
        #1;
        reset = 1'b0;
        clear_tracking();
    endtask

    initial begin
        vecs[0] = '{din: 8'hFC, exp_v: 1'b1, exp_d: 8'hFC};
        vecs[1] = '{din: 8'hBC, exp_v: 1'b0, exp_d: 8'hFC};
        vecs[2] = '{din: 8'h5A, exp_v: 1'b1, exp_d: 8'h5A};
        vecs[3] = '{din: 8'h00, exp_v: 1'b1, exp_d: 8'h00};
        vecs[4] = '{din: 8'hBC, exp_v: 1'b0, exp_d: 8'h00};
        vecs[5] = '{din: 8'hFF, exp_v: 1'b1, exp_d: 8'hFF};
        vecs[6] = '{din: 8'hBC, exp_v: 1'b0, exp_d: 8'hFF};

        do_reset();
        check("reset_active", 32'(active), 32'd0);
        check("reset_valid",  32'(valid_out), 32'd0);
        check("reset_data",   32'(data_out), 32'h00);

        // COM stream at bit offset 3: first match on edge 11, lock on edge 35
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'hBC, 1'b0);
        check("lock_edge",       32'(rise_n),  32'd35);
        check("first_match",     32'(rise1_n), 32'd11);
        check("no_valid_in_com", 32'(valid_seen), 32'd0);

        // Payload after lock, table-driven through the scoreboard
        last_exp = '{v: 1'b0, d: 8'h00};
        foreach (vecs[k]) begin
            sb.push_back('{v: vecs[k].exp_v, d: vecs[k].exp_d});
            send_byte(vecs[k].din, 1'b1);
        end

        // Broken alignment: 2 COMs then 0x00 returns to HUNT; 4 fresh COMs relock
        do_reset();
        send_byte(8'hBC, 1'b0);
        send_byte(8'hBC, 1'b0);
        send_byte(8'h00, 1'b0);
        check("no_lock_after_break", 32'(active), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'hBC, 1'b0);
        check("relock_edge",      32'(rise_n),  32'd56);
        check("relock_first_com", 32'(rise1_n), 32'd8);

        // Payload in the locked stream from the previous sequence
        last_exp = '{v: 1'b0, d: 8'h00};
        sb.push_back('{v: 1'b1, d: 8'h33});
        send_byte(8'h33, 1'b1);

        // Reset pulse mid-lock clears everything on the next edge
        reset   = 1'b1;
        data_in = 1'b0;
        @(posedge clk32_f);
        #1;
        check("rst_pulse_active", 32'(active), 32'd0);
        check("rst_pulse_valid",  32'(valid_out), 32'd0);
        check("rst_pulse_data",   32'(data_out), 32'h00);
        reset = 1'b0;
        clear_tracking();
        for (int i = 0; i < 4; i++) send_byte(8'hBC, 1'b0);
        check("post_rst_lock_edge", 32'(rise_n), 32'd32);

        // Straddling COM inside 0x5E 0x5E: earliest match at the 9th bit
        do_reset();
        send_byte(8'h5E, 1'b0);
        send_byte(8'h5E, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
        check("straddle_match_edge", 32'(rise1_n), 32'd9);
        check("straddle_no_lock",    32'(rise_n < 0), 32'd1);
        check("straddle_active",     32'(active), 32'd0);
        check("straddle_no_valid",   32'(valid_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_paralelo_rx
`default_nettype wire
